// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, count-width helper and sticky error record for the FIFO
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 32;
    localparam int FIFO_DEPTH_DEF = 16;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic conflict;
        logic underflow;
        logic overflow;
    } fifo_err_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port register array with synchronous write and registered, resettable read
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // storage is never cleared; only accepted writes touch it
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // read register holds its value unless a read is accepted
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with occupancy flags and sticky protocol-error flags
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [FIFO_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    output logic [FIFO_WIDTH-1:0]        data_out,
    output logic                         empty,
    output logic                         full,
    output logic [cnt_w(FIFO_DEPTH)-1:0] count,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         err_overflow,
    output logic                         err_underflow,
    output logic                         err_conflict,
    input  logic                         err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = cnt_w(FIFO_DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_ok, rd_ok;
    fifo_err_t     err, viol;

    assign empty        = count == '0;
    assign full         = count == CW'(FIFO_DEPTH);
    assign almost_full  = count >= CW'(AF_LEVEL);
    assign almost_empty = count <= CW'(AE_LEVEL);

    assign wr_ok = wr_en & ~rd_en & ~full;
    assign rd_ok = rd_en & ~wr_en & ~empty;
    assign viol  = {wr_en & rd_en, rd_en & ~wr_en & empty, wr_en & ~rd_en & full};

    assign err_conflict  = err.conflict;
    assign err_underflow = err.underflow;
    assign err_overflow  = err.overflow;

    // pointers wrap naturally; count is tracked separately so full/empty need no extra pointer bit
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok) count <= count + 1'b1;
            else if (rd_ok) count <= count - 1'b1;
        end
    end

    // sticky errors: clear first, then OR in new violations so a same-cycle violation survives the clear
    always_ff @(posedge clk) begin
        if (rst) err <= '0;
        else err <= (err_clr ? fifo_err_t'('0) : err) | viol;
    end

    fifo_mem #(
        .WIDTH(FIFO_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_ok),
        .waddr(wr_ptr),
        .wdata(data_in),
        .re   (rd_ok),
        .raddr(rd_ptr),
        .rdata(data_out)
    );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed plus random stimulus against a queue-based FIFO reference model
module tb_sync_fifo_ctrl;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AF = D - 2;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         empty, full, almost_full, almost_empty;
    logic         err_overflow, err_underflow, err_conflict;
    logic [4:0]   count;

    sync_fifo_ctrl #(
        .FIFO_WIDTH(W),
        .FIFO_DEPTH(D),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow),
        .err_conflict (err_conflict),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mq [$];
    logic [W-1:0] exp_q [$];
    logic         m_ov = 1'b0, m_un = 1'b0, m_cf = 1'b0;
    logic         pop_due = 1'b0, rst_due = 1'b0, chk_en = 1'b0;
    logic [W-1:0] exp_dout = '0;
    int           tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // one clock of stimulus; the model advances with the same inputs after the edge
    task automatic step(input logic w, input logic r, input logic [W-1:0] d, input logic clr, input logic rs);
        int n;
        logic cf, ov, un;
        wr_en = w; rd_en = r; data_in = d; err_clr = clr; rst = rs;
        @(posedge clk);
        #1;
        n = mq.size();
        pop_due = 1'b0;
        rst_due = rs;
        if (rs) begin
            mq.delete();
            {m_cf, m_un, m_ov} = 3'b000;
        end else begin
            cf = w && r;
            ov = w && !r && n == D;
            un = r && !w && n == 0;
            if (w && !r && n < D) mq.push_back(d);
            if (r && !w && n > 0) begin
                exp_q.push_back(mq.pop_front());
                pop_due = 1'b1;
            end
            m_cf = (clr ? 1'b0 : m_cf) | cf;
            m_un = (clr ? 1'b0 : m_un) | un;
            m_ov = (clr ? 1'b0 : m_ov) | ov;
        end
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
    endtask

    // monitor: compares every observable output against the model away from the active edge
    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            if (rst_due) exp_dout = '0;
            else if (pop_due) begin
                if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
                else exp_dout = exp_q.pop_front();
            end
            n = mq.size();
            chk("data_out", data_out, exp_dout);
            chk("count", W'(count), W'(n));
            chk("empty", W'(empty), W'(n == 0));
            chk("full", W'(full), W'(n == D));
            chk("almost_full", W'(almost_full), W'(n >= AF));
            chk("almost_empty", W'(almost_empty), W'(n <= AE));
            chk("err_overflow", W'(err_overflow), W'(m_ov));
            chk("err_underflow", W'(err_underflow), W'(m_un));
            chk("err_conflict", W'(err_conflict), W'(m_cf));
        end
    end

    initial begin
        step(0, 0, '0, 0, 1);
        chk_en = 1'b1;
        idle(3);
        for (int i = 0; i < 16; i++) step(1, 0, W'(32'hA0 + i), 0, 0);
        step(1, 0, 32'hFF, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, '0, 0, 0);
        step(0, 1, '0, 0, 0);
        idle(1);
        step(0, 0, '0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 0, W'(32'h10 + i), 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, '0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, W'(32'h100 + i), 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, '0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, W'(32'h200 + i), 0, 0);
        step(1, 1, 32'hDEAD, 0, 0);
        idle(1);
        step(0, 0, '0, 1, 0);
        step(1, 1, 32'hBEEF, 1, 0);
        idle(1);
        step(0, 0, '0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, '0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, W'(32'h300 + i), 0, 0);
        step(1, 0, 32'h3FF, 0, 1);
        idle(1);
        step(0, 1, '0, 0, 0);
        idle(1);
        for (int i = 0; i < 800; i++) begin
            logic w, r;
            w = $urandom_range(0, 99) < 55;
            r = $urandom_range(0, 99) < 45;
            step(w, r, $urandom, $urandom_range(0, 99) < 5, $urandom_range(0, 199) == 0);
        end
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
